note_sequencer: RTL and testbench

Upstream feeder for the note player: holds a small programmable song table of (period, duration) entries and, once started, presents each entry's period on its `period` output for that entry's duration, then advances. Its `period` output connects directly to the note player's 8-bit `period` input. Software or a testbench loads the table, pulses `play`, and watches `done`.

---
 rtl/note_seq_pkg.sv | 24 ++
 rtl/note_seq_mem.sv | 24 ++
 rtl/note_sequencer.sv | 131 +++++++++++++
 tb/tb_note_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// song table geometry and field widths.
package note_seq_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned DUR_W    = 8;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned ENTRY_W  = PERIOD_W + DUR_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StPlay = 2'd2,
    StDone = 2'd3
  } state_e;

  // Song length can never exceed the table depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : l;
  endfunction

endpackage

// File: rtl/note_seq_mem.sv
// Song table: 8 x {period, duration} register file, one synchronous write
// port and one combinational read port. Contents are intentionally not reset.
module note_seq_mem
  import note_seq_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/note_sequencer.sv
// Plays a programmable (period, duration) table: each entry's period is held
// on the output for duration x TICK_CYCLES cycles, with optional looping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [PERIOD_W-1:0] wperiod,
  input  logic [DUR_W-1:0]    wdur,
  input  logic [LEN_W-1:0]    len,
  input  logic                loop,
  input  logic                play,
  input  logic                stop,
  output logic [PERIOD_W-1:0] period,
  output logic [ADDR_W-1:0]   idx,
  output logic [1:0]          state,
  output logic                done
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic [15:0]         presc_q, presc_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic [ENTRY_W-1:0]  rd_entry;
  logic [PERIOD_W-1:0] rd_period;
  logic [DUR_W-1:0]    rd_dur;
  logic                tick;
  logic [LEN_W-1:0]    len_clamped;

  note_seq_mem u_mem (
    .clk_i   (clk),
    .we_i    (wen),
    .waddr_i (waddr),
    .wdata_i ({wperiod, wdur}),
    .raddr_i (idx_q),
    .rdata_o (rd_entry)
  );

  assign rd_period   = rd_entry[ENTRY_W-1:DUR_W];
  assign rd_dur      = rd_entry[DUR_W-1:0];
  assign tick        = (presc_q == 16'(TICK_CYCLES - 1));
  assign len_clamped = clamp_len(len);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    len_d    = len_q;

    unique case (state_q)
      StIdle: begin
        if (play) begin
          len_d   = len_clamped;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        period_d = rd_period;
        rem_d    = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
        presc_d  = '0;
        state_d  = StPlay;
      end
      StPlay: begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        if (tick) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            if (({1'b0, idx_q} + LEN_W'(1)) < len_q) begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = StLoad;
            end else if (loop) begin
              idx_d   = '0;
              state_d = StLoad;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over play and over any note-end decision made above.
    if (stop) begin
      state_d  = StIdle;
      presc_d  = '0;
      idx_d    = '0;
      period_d = '0;
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      period_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      rem_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
    end
  end

  assign period = period_q;
  assign idx    = idx_q;
  assign state  = state_q;
  assign done   = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=4: expected per-cycle
// outputs are queued ahead of each step and popped as the DUT advances.
module tb_note_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] per;
    logic [2:0] ix;
    logic       dn;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, wen, loop, play, stop;
  logic [2:0] waddr;
  logic [7:0] wperiod, wdur;
  logic [3:0] len;
  logic [7:0] period;
  logic [2:0] idx;
  logic [1:0] state;
  logic       done;

  obs_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  note_sequencer #(.TICK_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .wperiod (wperiod),
    .wdur    (wdur),
    .len     (len),
    .loop    (loop),
    .play    (play),
    .stop    (stop),
    .period  (period),
    .idx     (idx),
    .state   (state),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [1:0] st, input logic [7:0] per, input logic [2:0] ix,
                      input logic dn, input int n);
    obs_t e;
    e = {st, per, ix, dn};
    repeat (n) exp_q.push_back(e);
  endtask

  // Advance one clock and compare the outputs against the next queued entry.
  task automatic check_next(input string tag);
    obs_t e, o;
    @(posedge clk);
    #1;
    o = {state, period, idx, done};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed st=%0d per=%0d idx=%0d done=%0b",
             tag, o.st, o.per, o.ix, o.dn);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed st=%0d per=%0d idx=%0d done=%0b, expected st=%0d per=%0d idx=%0d done=%0b",
               tag, o.st, o.per, o.ix, o.dn, e.st, e.per, e.ix, e.dn);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) check_next(tag);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
    wen = 1'b1; waddr = a; wperiod = p; wdur = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; loop = 1'b0; play = 1'b0; stop = 1'b0;
    waddr = '0; wperiod = '0; wdur = '0; len = '0;

    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("reset");
    rst = 1'b0;

    // Basic song
    wr(3'd0, 8'd10, 8'd2);
    wr(3'd1, 8'd20, 8'd1);
    wr(3'd2, 8'd30, 8'd3);
    len = 4'd3; loop = 1'b0; play = 1'b1;
    push(S_LOAD, 8'd0, 3'd0, 1'b0, 1);
    check_next("basic_load0");
    play = 1'b0;
    push(S_PLAY, 8'd10, 3'd0, 1'b0, 8);
    push(S_LOAD, 8'd10, 3'd1, 1'b0, 1);
    push(S_PLAY, 8'd20, 3'd1, 1'b0, 4);
    push(S_LOAD, 8'd20, 3'd2, 1'b0, 1);
    push(S_PLAY, 8'd30, 3'd2, 1'b0, 12);
    push(S_DONE, 8'd30, 3'd2, 1'b1, 1);
    push(S_IDLE, 8'd30, 3'd2, 1'b0, 2);
    drain("basic");

    // Zero duration plays one tick
    wr(3'd0, 8'd5, 8'd0);
    len = 4'd1; play = 1'b1;
    push(S_LOAD, 8'd30, 3'd0, 1'b0, 1);
    check_next("zdur_load");
    play = 1'b0;
    push(S_PLAY, 8'd5, 3'd0, 1'b0, 4);
    push(S_DONE, 8'd5, 3'd0, 1'b1, 1);
    push(S_IDLE, 8'd5, 3'd0, 1'b0, 1);
    drain("zdur");

    // Zero length goes straight to DONE
    len = 4'd0; play = 1'b1;
    push(S_DONE, 8'd5, 3'd0, 1'b1, 1);
    check_next("zlen_done");
    play = 1'b0;
    push(S_IDLE, 8'd5, 3'd0, 1'b0, 2);
    drain("zlen");

    // Looping with a live rewrite of entry 0, then loop released in entry 1
    wr(3'd0, 8'd11, 8'd1);
    wr(3'd1, 8'd22, 8'd1);
    len = 4'd2; loop = 1'b1; play = 1'b1;
    push(S_LOAD, 8'd5, 3'd0, 1'b0, 1);
    check_next("loop_load0");
    play = 1'b0;
    push(S_PLAY, 8'd11, 3'd0, 1'b0, 1);
    drain("loop_play0");
    wen = 1'b1; waddr = 3'd0; wperiod = 8'd99; wdur = 8'd1;
    push(S_PLAY, 8'd11, 3'd0, 1'b0, 1);
    check_next("live_write");
    wen = 1'b0;
    push(S_PLAY, 8'd11, 3'd0, 1'b0, 2);
    push(S_LOAD, 8'd11, 3'd1, 1'b0, 1);
    push(S_PLAY, 8'd22, 3'd1, 1'b0, 4);
    push(S_LOAD, 8'd22, 3'd0, 1'b0, 1);
    push(S_PLAY, 8'd99, 3'd0, 1'b0, 4);
    push(S_LOAD, 8'd99, 3'd1, 1'b0, 1);
    push(S_PLAY, 8'd22, 3'd1, 1'b0, 2);
    drain("loop_pass");
    loop = 1'b0;
    push(S_PLAY, 8'd22, 3'd1, 1'b0, 2);
    push(S_DONE, 8'd22, 3'd1, 1'b1, 1);
    push(S_IDLE, 8'd22, 3'd1, 1'b0, 1);
    drain("loop_end");

    // Stop three cycles into PLAY
    len = 4'd2; play = 1'b1;
    push(S_LOAD, 8'd22, 3'd0, 1'b0, 1);
    check_next("stop_load");
    play = 1'b0;
    push(S_PLAY, 8'd99, 3'd0, 1'b0, 3);
    drain("stop_play");
    stop = 1'b1;
    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("stop_mid");
    stop = 1'b0;

    // Stop coincident with the note-end tick
    play = 1'b1;
    push(S_LOAD, 8'd0, 3'd0, 1'b0, 1);
    check_next("stopend_load");
    play = 1'b0;
    push(S_PLAY, 8'd99, 3'd0, 1'b0, 4);
    drain("stopend_play");
    stop = 1'b1;
    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("stop_at_tick");
    stop = 1'b0;

    // play and stop together in IDLE
    play = 1'b1; stop = 1'b1;
    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("play_stop");
    play = 1'b0; stop = 1'b0;
    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("play_stop_idle");

    // Reset mid-play, then replay from the retained table
    play = 1'b1;
    push(S_LOAD, 8'd0, 3'd0, 1'b0, 1);
    check_next("rst_load");
    play = 1'b0;
    push(S_PLAY, 8'd99, 3'd0, 1'b0, 2);
    drain("rst_play");
    rst = 1'b1;
    push(S_IDLE, 8'd0, 3'd0, 1'b0, 1);
    check_next("rst_mid");
    rst = 1'b0;
    play = 1'b1;
    push(S_LOAD, 8'd0, 3'd0, 1'b0, 1);
    check_next("replay_load");
    play = 1'b0;
    push(S_PLAY, 8'd99, 3'd0, 1'b0, 4);
    push(S_LOAD, 8'd99, 3'd1, 1'b0, 1);
    push(S_PLAY, 8'd22, 3'd1, 1'b0, 4);
    push(S_DONE, 8'd22, 3'd1, 1'b1, 1);
    push(S_IDLE, 8'd22, 3'd1, 1'b0, 1);
    drain("replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
